// File: rtl/tile_operand_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tile_operand_fetcher
// Description : Answers the systolic controller's tile-load handshake; fetches
//               one K-column of A and B per beat into the tile operand buffers,
//               zero-padding the tail of the last partial tile.
// Revision    : 1.0
// ============================================================================
module tile_operand_fetcher #(
    parameter int BUFFER_SIZE = 9,
    parameter int K_SIZE      = 27,
    parameter int M_SIZE      = 16,
    parameter int N_SIZE      = 16,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 10,
    parameter int A_BASE      = 0,
    parameter int B_BASE      = 512,
    localparam int BEAT_W     = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       read_data,
    input  logic                       done,
    output logic                       data_valid,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_addr_a,
    output logic [ADDR_W-1:0]          mem_addr_b,
    input  logic [M_SIZE*DATA_W-1:0]   mem_rdata_a,
    input  logic [N_SIZE*DATA_W-1:0]   mem_rdata_b,
    output logic                       buf_wr_en,
    output logic [BEAT_W-1:0]          buf_wr_addr,
    output logic [M_SIZE*DATA_W-1:0]   buf_wdata_a,
    output logic [N_SIZE*DATA_W-1:0]   buf_wdata_b,
    output logic                       busy,
    output logic                       fetch_done,
    output logic                       overrun_err
);

    localparam int TILING = (K_SIZE + BUFFER_SIZE - 1) / BUFFER_SIZE;
    localparam int TILE_W = $clog2(TILING + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_FETCH  = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t              state;
    logic [TILE_W-1:0]   tile;
    logic [BEAT_W-1:0]   beat;
    logic                rd_q;
    logic                pad_q;

    logic                rd_rise;
    logic                issue;
    logic                in_range;
    logic                last_beat;
    logic                last_tile;
    logic [31:0]         k_idx;

    assign rd_rise   = read_data & ~rd_q;
    assign k_idx     = 32'(tile) * 32'(BUFFER_SIZE) + 32'(beat);
    assign in_range  = (k_idx < 32'(K_SIZE));
    assign last_beat = (beat == BEAT_W'(BUFFER_SIZE - 1));
    assign last_tile = ((32'(tile) + 32'd1) == 32'(TILING));

    // done wins over a beat request in the same cycle: the job is over.
    always_comb begin
        issue = 1'b0;
        if (!done) begin
            case (state)
                S_ARM, S_FETCH: issue = read_data;
                S_GAP:          issue = rd_rise;
                default:        issue = 1'b0;
            endcase
        end
    end

    assign mem_rd_en   = issue & in_range;
    assign mem_addr_a  = mem_rd_en ? ADDR_W'(32'(A_BASE) + k_idx) : '0;
    assign mem_addr_b  = mem_rd_en ? ADDR_W'(32'(B_BASE) + k_idx) : '0;
    assign buf_wdata_a = pad_q ? '0 : mem_rdata_a;
    assign buf_wdata_b = pad_q ? '0 : mem_rdata_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tile        <= '0;
            beat        <= '0;
            rd_q        <= 1'b0;
            pad_q       <= 1'b0;
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
            fetch_done  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rd_q        <= read_data;
            buf_wr_en   <= issue;
            buf_wr_addr <= beat;
            pad_q       <= issue & ~in_range;
            fetch_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_ARM;
                        tile        <= '0;
                        beat        <= '0;
                        overrun_err <= 1'b0;
                        data_valid  <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                S_ARM, S_FETCH, S_GAP: begin
                    if (done) begin
                        state      <= S_IDLE;
                        fetch_done <= 1'b1;
                        data_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (issue) begin
                        if (last_beat) begin
                            beat <= '0;
                            tile <= tile + TILE_W'(1);
                            if (last_tile) begin
                                state      <= S_FINISH;
                                data_valid <= 1'b0;
                            end else begin
                                state <= S_GAP;
                            end
                        end else begin
                            beat  <= beat + BEAT_W'(1);
                            state <= S_FETCH;
                        end
                    end
                end
                S_FINISH: begin
                    if (rd_rise) overrun_err <= 1'b1;
                    if (done) begin
                        state      <= S_IDLE;
                        fetch_done <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    data_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_operand_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_operand_fetcher
// Description : Randomised-memory bench; expected reads/writes are derived from
//               the column index k of each beat and a word array memory model.
// Revision    : 1.0
// ============================================================================
module tb_tile_operand_fetcher;

    localparam int W = 128;

    logic clk = 1'b0;
    logic rst_n, start, read_data, done;
    always #5 clk = ~clk;

    // Instance 0: default K_SIZE=27; instance 1: K_SIZE=20 (partial last tile)
    logic          dv0, rd_en0, wr_en0, busy0, fd0, ov0;
    logic [9:0]    addr_a0, addr_b0;
    logic [3:0]    wr_addr0;
    logic [W-1:0]  rdata_a0, rdata_b0, wda0, wdb0;
    logic          dv1, rd_en1, wr_en1, busy1, fd1, ov1;
    logic [9:0]    addr_a1, addr_b1;
    logic [3:0]    wr_addr1;
    logic [W-1:0]  rdata_a1, rdata_b1, wda1, wdb1;

    tile_operand_fetcher dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .read_data(read_data), .done(done),
        .data_valid(dv0), .mem_rd_en(rd_en0), .mem_addr_a(addr_a0), .mem_addr_b(addr_b0),
        .mem_rdata_a(rdata_a0), .mem_rdata_b(rdata_b0), .buf_wr_en(wr_en0),
        .buf_wr_addr(wr_addr0), .buf_wdata_a(wda0), .buf_wdata_b(wdb0),
        .busy(busy0), .fetch_done(fd0), .overrun_err(ov0));

    tile_operand_fetcher #(.K_SIZE(20)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .read_data(read_data), .done(done),
        .data_valid(dv1), .mem_rd_en(rd_en1), .mem_addr_a(addr_a1), .mem_addr_b(addr_b1),
        .mem_rdata_a(rdata_a1), .mem_rdata_b(rdata_b1), .buf_wr_en(wr_en1),
        .buf_wr_addr(wr_addr1), .buf_wdata_a(wda1), .buf_wdata_b(wdb1),
        .busy(busy1), .fetch_done(fd1), .overrun_err(ov1));

    logic [W-1:0] mem_a [1024];
    logic [W-1:0] mem_b [1024];

    always @(posedge clk) begin
        if (rd_en0) begin rdata_a0 <= mem_a[addr_a0]; rdata_b0 <= mem_b[addr_b0]; end
        if (rd_en1) begin rdata_a1 <= mem_a[addr_a1]; rdata_b1 <= mem_b[addr_b1]; end
    end

    typedef struct {
        int           cyc;
        int           a;
        int           b;
        logic [W-1:0] da;
        logic [W-1:0] db;
    } rec_t;

    rec_t rd0[$], wr0[$], rd1[$], wr1[$];
    rec_t mr;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        mr.cyc = cyc;
        if (rd_en0) begin mr.a = int'(addr_a0); mr.b = int'(addr_b0); mr.da = '0; mr.db = '0; rd0.push_back(mr); end
        if (wr_en0) begin mr.a = int'(wr_addr0); mr.b = 0; mr.da = wda0; mr.db = wdb0; wr0.push_back(mr); end
        if (rd_en1) begin mr.a = int'(addr_a1); mr.b = int'(addr_b1); mr.da = '0; mr.db = '0; rd1.push_back(mr); end
        if (wr_en1) begin mr.a = int'(wr_addr1); mr.b = 0; mr.da = wda1; mr.db = wdb1; wr1.push_back(mr); end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        rd0.delete(); wr0.delete(); rd1.delete(); wr1.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic burst(input int n);
        read_data = 1'b1;
        repeat (n) tick();
        read_data = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; read_data = 1'b0; done = 1'b0;
        tick(); tick();
        checks++;
        if ({dv0, busy0, wr_en0, rd_en0, fd0, ov0} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000", {dv0, busy0, wr_en0, rd_en0, fd0, ov0});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy0 !== 1'b0 || dv0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b dv=%b want 0 0", busy0, dv0);
        end
    endtask

    task automatic test_full_job();
        clear_logs();
        pulse_start();
        checks++;
        if (dv0 !== 1'b1 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL arm_flags dv=%b busy=%b want 1 1", dv0, busy0);
        end
        burst(9); burst(9); burst(9);
        tick();
        checks++;
        if (rd0.size() != 27 || wr0.size() != 27) begin
            errors++;
            $display("FAIL job_counts reads=%0d writes=%0d want 27 27", rd0.size(), wr0.size());
        end else begin
            for (int k = 0; k < 27; k++) begin
                checks++;
                if (rd0[k].a != k || rd0[k].b != 512 + k) begin
                    errors++;
                    $display("FAIL read_addr k=%0d got a=%0d b=%0d want %0d %0d", k, rd0[k].a, rd0[k].b, k, 512 + k);
                end
                checks++;
                if (wr0[k].a != k % 9 || wr0[k].cyc != rd0[k].cyc + 1 ||
                    wr0[k].da !== mem_a[k] || wr0[k].db !== mem_b[512 + k]) begin
                    errors++;
                    $display("FAIL write k=%0d slot=%0d want %0d dcyc=%0d want 1 da=%h want %h",
                             k, wr0[k].a, k % 9, wr0[k].cyc - rd0[k].cyc, wr0[k].da, mem_a[k]);
                end
            end
        end
        checks++;
        if (dv0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL finish_flags dv=%b busy=%b want 0 1", dv0, busy0);
        end
        done = 1'b1; tick(); done = 1'b0;
        checks++;
        if (fd0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse fd=%b busy=%b want 1 0", fd0, busy0);
        end
        tick();
        checks++;
        if (fd0 !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle fd=%b want 0", fd0);
        end
    endtask

    // Uses the logs left by test_full_job for the K_SIZE=20 instance
    task automatic test_pad();
        checks++;
        if (rd1.size() != 20 || wr1.size() != 27) begin
            errors++;
            $display("FAIL pad_counts reads=%0d writes=%0d want 20 27", rd1.size(), wr1.size());
        end else begin
            for (int k = 0; k < 27; k++) begin
                if (k < 20) begin
                    checks++;
                    if (rd1[k].a != k || wr1[k].cyc != rd1[k].cyc + 1 ||
                        wr1[k].da !== mem_a[k] || wr1[k].db !== mem_b[512 + k]) begin
                        errors++;
                        $display("FAIL pad_real k=%0d addr=%0d want %0d da=%h want %h", k, rd1[k].a, k, wr1[k].da, mem_a[k]);
                    end
                end else begin
                    checks++;
                    if (wr1[k].a != k % 9 || wr1[k].da !== '0 || wr1[k].db !== '0 ||
                        wr1[k].cyc - 1 <= rd1[19].cyc) begin
                        errors++;
                        $display("FAIL pad_zero k=%0d slot=%0d want %0d da=%h db=%h want 0", k, wr1[k].a, k % 9, wr1[k].da, wr1[k].db);
                    end
                end
            end
        end
    endtask

    task automatic test_hold_stall();
        clear_logs();
        pulse_start();
        read_data = 1'b1; repeat (4) tick();
        read_data = 1'b0; repeat (3) tick();
        checks++;
        if (rd0.size() != 4) begin
            errors++;
            $display("FAIL stall reads=%0d want 4", rd0.size());
        end
        read_data = 1'b1; repeat (5) tick();
        read_data = 1'b0; tick();
        read_data = 1'b1; repeat (11) tick();
        read_data = 1'b0; tick();
        checks++;
        if (rd0.size() != 18) begin
            errors++;
            $display("FAIL hold11 reads=%0d want 18", rd0.size());
        end
        read_data = 1'b1; repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        read_data = 1'b0; tick(); tick();
        checks++;
        if (rd0.size() != 27) begin
            errors++;
            $display("FAIL seq_count reads=%0d want 27", rd0.size());
        end else begin
            for (int k = 0; k < 27; k++) begin
                checks++;
                if (rd0[k].a != k || wr0[k].a != k % 9) begin
                    errors++;
                    $display("FAIL seq_addr k=%0d got %0d slot %0d want %0d %0d", k, rd0[k].a, wr0[k].a, k, k % 9);
                end
            end
        end
        done = 1'b1; tick(); done = 1'b0;
        checks++;
        if (fd0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL hold_done fd=%b busy=%b want 1 0", fd0, busy0);
        end
    endtask

    task automatic test_overrun();
        clear_logs();
        pulse_start();
        burst(9); burst(9); burst(9);
        tick();
        read_data = 1'b1; tick(); read_data = 1'b0;
        checks++;
        if (ov0 !== 1'b1 || rd0.size() != 27) begin
            errors++;
            $display("FAIL overrun ov=%b reads=%0d want 1 27", ov0, rd0.size());
        end
        done = 1'b1; tick(); done = 1'b0;
        checks++;
        if (fd0 !== 1'b1 || ov0 !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky fd=%b ov=%b want 1 1", fd0, ov0);
        end
        pulse_start();
        checks++;
        if (ov0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL overrun_clear ov=%b busy=%b want 0 1", ov0, busy0);
        end
        done = 1'b1; tick(); done = 1'b0;
        checks++;
        if (fd0 !== 1'b1 || busy0 !== 1'b0 || rd0.size() != 27) begin
            errors++;
            $display("FAIL done_in_arm fd=%b busy=%b reads=%0d want 1 0 27", fd0, busy0, rd0.size());
        end
    endtask

    task automatic test_done_with_rise();
        pulse_start();
        burst(9); burst(9); burst(9);
        tick();
        read_data = 1'b1; done = 1'b1; tick(); read_data = 1'b0; done = 1'b0;
        checks++;
        if (fd0 !== 1'b1 || ov0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL done_and_rise fd=%b ov=%b busy=%b want 1 1 0", fd0, ov0, busy0);
        end
    endtask

    task automatic test_mid_reset();
        clear_logs();
        pulse_start();
        burst(9);
        read_data = 1'b1; repeat (5) tick();
        checks++;
        if (wr_en0 !== 1'b1 || rd_en0 !== 1'b1 || addr_a0 !== 10'd14) begin
            errors++;
            $display("FAIL pre_reset wr=%b rd=%b addr=%0d want 1 1 14", wr_en0, rd_en0, addr_a0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wr_en0 !== 1'b0 || dv0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset wr=%b dv=%b busy=%b want 0 0 0", wr_en0, dv0, busy0);
        end
        read_data = 1'b0;
        tick(); rst_n = 1'b1; tick();
        clear_logs();
        pulse_start();
        read_data = 1'b1; tick(); read_data = 1'b0; tick();
        checks++;
        if (rd0.size() != 1) begin
            errors++;
            $display("FAIL restart reads=%0d want 1", rd0.size());
        end else begin
            checks++;
            if (rd0[0].a != 0 || rd0[0].b != 512) begin
                errors++;
                $display("FAIL restart_addr got %0d %0d want 0 512", rd0[0].a, rd0[0].b);
            end
        end
        done = 1'b1; tick(); done = 1'b0; tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = {$urandom, $urandom, $urandom, $urandom};
            mem_b[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        test_reset();
        test_full_job();
        test_pad();
        test_hold_stall();
        test_overrun();
        test_done_with_rise();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
